// File: rtl/dac_slew_driver_pkg.sv
// Shared types and defaults for the DAC slew driver: FSM state encoding,
// default geometry and the settle-counter width helper.
package dac_slew_driver_pkg;

  localparam int DEF_DAC_WIDTH     = 12;
  localparam int DEF_MAX_STEP      = 16;
  localparam int DEF_SETTLE_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // One extra bit so the terminal value SETTLE_CYCLES-1 always fits.
  function automatic int timer_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/dac_slew_driver_if.sv
// Setpoint handshake and DAC-side outputs of one slew driver channel.
interface dac_slew_driver_if
  import dac_slew_driver_pkg::*;
#(
  parameter int DAC_WIDTH = DEF_DAC_WIDTH
);

  logic                        set_valid;
  logic                        set_ready;
  logic signed [DAC_WIDTH-1:0] set_data;
  logic                        abort;
  logic signed [DAC_WIDTH-1:0] dac_data;
  logic                        dac_we;
  logic                        busy;
  logic                        settled;

  modport master (
    output set_valid, set_data, abort,
    input  set_ready, dac_data, dac_we, busy, settled
  );

  modport slave (
    input  set_valid, set_data, abort,
    output set_ready, dac_data, dac_we, busy, settled
  );

endinterface

// File: rtl/dac_slew_driver_settle_timer.sv
// Settle timer: loads CYCLES-1, counts down once per cycle and emits a
// registered one-cycle done pulse on the cycle after reaching zero.
module settle_timer #(
  parameter int CYCLES = 64,
  parameter int WIDTH  = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic done
);

  localparam logic [WIDTH-1:0] LOAD_VALUE = WIDTH'(CYCLES - 1);

  logic [WIDTH-1:0] count_reg;
  logic             active_reg;
  logic             done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (clear) begin
        active_reg <= 1'b0;
      end else if (load) begin
        count_reg  <= LOAD_VALUE;
        active_reg <= 1'b1;
      end else if (active_reg) begin
        if (count_reg == '0) begin
          done_reg   <= 1'b1;
          active_reg <= 1'b0;
        end else begin
          count_reg <= count_reg - 1'b1;
        end
      end
    end
  end

  assign done = done_reg;

endmodule

// File: rtl/dac_slew_driver.sv
// Slew-limited signed DAC driver: ramps toward an accepted setpoint at most
// MAX_STEP LSB per cycle, waits for the analog path, then pulses settled.
module dac_slew_driver
  import dac_slew_driver_pkg::*;
#(
  parameter int DAC_WIDTH     = DEF_DAC_WIDTH,
  parameter int MAX_STEP      = DEF_MAX_STEP,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RESET_CODE    = 0
) (
  input  logic               CLK,
  input  logic               RST,
  dac_slew_driver_if.slave   bus
);

  localparam int TIMER_WIDTH = timer_width(SETTLE_CYCLES);
  localparam logic signed [DAC_WIDTH:0]   STEP      = (DAC_WIDTH+1)'(MAX_STEP);
  localparam logic signed [DAC_WIDTH-1:0] RESET_VAL = DAC_WIDTH'(RESET_CODE);

  state_t                      state_reg;
  logic signed [DAC_WIDTH-1:0] target_reg;
  logic signed [DAC_WIDTH-1:0] dac_reg;
  logic                        dac_we_reg;

  logic signed [DAC_WIDTH:0]   diff;
  logic signed [DAC_WIDTH:0]   diff_abs;
  logic signed [DAC_WIDTH:0]   dac_ext;
  logic signed [DAC_WIDTH:0]   step_next;
  logic                        last_step;
  logic                        accept;
  logic                        timer_load;
  logic                        timer_clear;
  logic                        timer_done;

  // One extra bit keeps full-scale swings (e.g. +2047 -> -2048) from wrapping.
  always_comb begin
    dac_ext   = {dac_reg[DAC_WIDTH-1], dac_reg};
    diff      = {target_reg[DAC_WIDTH-1], target_reg} - dac_ext;
    diff_abs  = diff[DAC_WIDTH] ? -diff : diff;
    step_next = diff[DAC_WIDTH] ? (dac_ext - STEP) : (dac_ext + STEP);
    last_step = (diff_abs <= STEP);
  end

  assign accept      = (state_reg == ST_IDLE) && bus.set_valid && !bus.abort;
  assign timer_clear = bus.abort && (state_reg != ST_IDLE);
  assign timer_load  = (accept && (bus.set_data == dac_reg))
                     || ((state_reg == ST_RAMP) && last_step);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      target_reg <= RESET_VAL;
      dac_reg    <= RESET_VAL;
      dac_we_reg <= 1'b0;
    end else begin
      dac_we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            target_reg <= bus.set_data;
            state_reg  <= (bus.set_data == dac_reg) ? ST_SETTLE : ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (bus.abort) begin
            state_reg <= ST_IDLE;
          end else if (last_step) begin
            dac_reg    <= target_reg;
            dac_we_reg <= 1'b1;
            state_reg  <= ST_SETTLE;
          end else begin
            dac_reg    <= step_next[DAC_WIDTH-1:0];
            dac_we_reg <= 1'b1;
          end
        end
        ST_SETTLE: begin
          // Stay busy through the settled pulse; ready returns afterwards.
          if (bus.abort || timer_done) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  settle_timer #(
    .CYCLES (SETTLE_CYCLES),
    .WIDTH  (TIMER_WIDTH)
  ) u_settle_timer (
    .clk   (CLK),
    .rst   (RST),
    .load  (timer_load),
    .clear (timer_clear),
    .done  (timer_done)
  );

  assign bus.dac_data  = dac_reg;
  assign bus.dac_we    = dac_we_reg;
  assign bus.set_ready = (state_reg == ST_IDLE);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.settled   = timer_done;

endmodule
